alu_pwr_ctrl: RTL

//  Power-sequencing controller directly upstream of the gated ALU and its always-on result path.

---
 rtl/alu_pwr_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing controller for the gated ALU.
// Turns level sleep/wake requests into ordered save/isolate/power-off and
// power-on/restore/un-isolate sequences, and gates ALU start outside ACTIVE.
module alu_pwr_ctrl #(
    parameter int unsigned ISO_DLY     = 2,
    parameter int unsigned PWR_UP_DLY  = 4,
    parameter int unsigned RESTORE_CYC = 1,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sleep_req,
    input  logic       wake_req,
    input  logic       alu_busy,
    input  logic       start_in,
    output logic       start_out,
    output logic       alu_pwr_en,
    output logic       iso_en,
    output logic       save,
    output logic       restore,
    output logic       sleep_ack,
    output logic       seq_busy,
    output logic [2:0] pwr_state
);

    typedef enum logic [2:0] {
        ST_ACTIVE  = 3'd0,
        ST_SAVE    = 3'd1,
        ST_ISO     = 3'd2,
        ST_SLEEP   = 3'd3,
        ST_PWR_UP  = 3'd4,
        ST_RESTORE = 3'd5,
        ST_ISO_REL = 3'd6
    } state_t;

    // Dwell-counter reload values (N-1) for the multi-cycle states.
    localparam logic [CNT_W-1:0] ISO_LD     = CNT_W'(ISO_DLY - 1);
    localparam logic [CNT_W-1:0] PWR_UP_LD  = CNT_W'(PWR_UP_DLY - 1);
    localparam logic [CNT_W-1:0] RESTORE_LD = CNT_W'(RESTORE_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next-state and dwell-counter logic; unreachable code 7 falls back to ACTIVE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_ACTIVE:  if (sleep_req && !alu_busy) state_nxt = ST_SAVE;
            ST_SAVE:    state_nxt = ST_ISO;
            ST_ISO:     if (cnt == '0) state_nxt = ST_SLEEP;
            ST_SLEEP:   if (wake_req) state_nxt = ST_PWR_UP;
            ST_PWR_UP:  if (cnt == '0) state_nxt = ST_RESTORE;
            ST_RESTORE: if (cnt == '0) state_nxt = ST_ISO_REL;
            ST_ISO_REL: state_nxt = ST_ACTIVE;
            default:    state_nxt = ST_ACTIVE;
        endcase

        if (state_nxt != state) begin
            case (state_nxt)
                ST_ISO:     cnt_nxt = ISO_LD;
                ST_PWR_UP:  cnt_nxt = PWR_UP_LD;
                ST_RESTORE: cnt_nxt = RESTORE_LD;
                default:    cnt_nxt = '0;
            endcase
        end else if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // State, counter and registered Moore output decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ACTIVE;
            cnt        <= '0;
            alu_pwr_en <= 1'b1;
            iso_en     <= 1'b0;
            save       <= 1'b0;
            restore    <= 1'b0;
            sleep_ack  <= 1'b0;
            seq_busy   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            alu_pwr_en <= (state_nxt != ST_SLEEP);
            iso_en     <= (state_nxt == ST_ISO)    || (state_nxt == ST_SLEEP) ||
                          (state_nxt == ST_PWR_UP) || (state_nxt == ST_RESTORE);
            save       <= (state_nxt == ST_SAVE);
            restore    <= (state_nxt == ST_RESTORE);
            sleep_ack  <= (state_nxt == ST_SLEEP);
            seq_busy   <= (state_nxt != ST_ACTIVE) && (state_nxt != ST_SLEEP);
        end
    end

    // State register is already clocked, so its encoding is glitch-free.
    assign pwr_state = state;

    // ALU launch gate: only in ACTIVE and never once sleep is being requested.
    assign start_out = start_in && (state == ST_ACTIVE) && !sleep_req;

endmodule
